// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
package addsub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_fa_bit.sv
// Single combinational full-adder cell, reused for every bit position.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    // Sum and majority carry.
    always_comb begin
        s = a ^ b ^ cin;
        c = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a
// single full-adder cell. Subtraction is A + ~B + 1 (carry preset to m).
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             v
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_msb_q, c_msb_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             v_q, v_d;

    logic fa_s, fa_c;

    fa_bit u_fa (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .c   (fa_c)
    );

    // Next-state: FSM, operand shifting, result assembly.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_msb_d = c_msb_q;
        s_d     = s_q;
        cout_d  = cout_q;
        v_d     = v_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = B ^ {WIDTH{m}};
                    carry_d = m;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + 1'b1;
                // Carry out of bit WIDTH-2 is the carry into the MSB,
                // needed for the overflow flag on the final edge.
                if (cnt_q == CNT_PENULT) begin
                    c_msb_d = fa_c;
                end
                if (cnt_q == CNT_LAST) begin
                    s_d     = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    v_d     = c_msb_q ^ fa_c;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_msb_q <= c_msb_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign S    = s_q;
    assign cout = cout_q;
    assign v    = v_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and exhaustive checks for serial_addsub at WIDTH=4.
module tb_serial_addsub;

    localparam int W = 4;

    logic         clk, rst_n, start, m;
    logic [W-1:0] A, B;
    logic         busy, done, cout, v;
    logic [W-1:0] S;

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .m(m),
        .busy(busy), .done(done), .S(S), .cout(cout), .v(v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a start request now (caller sits on a falling edge).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic mm);
        start = 1'b1;
        A = a;
        B = b;
        m = mm;
    endtask

    // Wait for done; optionally re-assert start with 1+1 at cycle inj.
    task automatic wait_done(input int inj, output int lat, output int bcnt, output logic seen);
        lat = 0;
        bcnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            start = (lat == inj);
            if (lat == inj) begin
                A = 4'd1;
                B = 4'd1;
                m = 1'b0;
            end
            if (done) seen = 1'b1;
            else if (busy) bcnt++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: done never seen, required within 20 cycles");
        end
    endtask

    // Golden model, computed from signed/unsigned arithmetic directly.
    function automatic logic [W+1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b, input logic mm);
        logic [W:0] full;
        logic [W-1:0] s;
        logic ov;
        if (mm) full = {1'b0, a} + {1'b0, ~b} + 1;
        else    full = {1'b0, a} + {1'b0, b};
        s = full[W-1:0];
        if (mm) ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        else    ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {s, full[W], ov};
    endfunction

    initial begin
        int lat, bcnt, ndone;
        logic seen;
        logic [W+1:0] g;

        vecs[0] = '{a: 4'd5,  b: 4'd3, m: 1'b1, s: 4'd2,  co: 1'b1, ov: 1'b0};
        vecs[1] = '{a: 4'd7,  b: 4'd1, m: 1'b0, s: 4'd8,  co: 1'b0, ov: 1'b1};
        vecs[2] = '{a: 4'd8,  b: 4'd1, m: 1'b1, s: 4'd7,  co: 1'b1, ov: 1'b1};
        vecs[3] = '{a: 4'd0,  b: 4'd0, m: 1'b1, s: 4'd0,  co: 1'b1, ov: 1'b0};
        vecs[4] = '{a: 4'd15, b: 4'd1, m: 1'b0, s: 4'd0,  co: 1'b1, ov: 1'b0};
        vecs[5] = '{a: 4'd3,  b: 4'd5, m: 1'b1, s: 4'd14, co: 1'b0, ov: 1'b0};

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; m = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_S",    32'(S),    0);
        chk("reset_cout", 32'(cout), 0);
        chk("reset_v",    32'(v),    0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors.
        foreach (vecs[i]) begin
            @(negedge clk);
            issue(vecs[i].a, vecs[i].b, vecs[i].m);
            wait_done(0, lat, bcnt, seen);
            chk($sformatf("vec%0d_S", i),    32'(S),    32'(vecs[i].s));
            chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].co));
            chk($sformatf("vec%0d_v", i),    32'(v),    32'(vecs[i].ov));
            chk($sformatf("vec%0d_lat", i),  lat,       W + 1);
            chk($sformatf("vec%0d_busy", i), bcnt,      W);
        end

        // Start during RUN is ignored: 5-3 still completes on schedule.
        @(negedge clk);
        issue(4'd5, 4'd3, 1'b1);
        wait_done(2, lat, bcnt, seen);
        chk("ign_S",    32'(S),    2);
        chk("ign_cout", 32'(cout), 1);
        chk("ign_lat",  lat,       W + 1);
        @(negedge clk);
        chk("ign_idle_after", 32'(busy), 0);

        // Back-to-back: start held in the DONE cycle.
        @(negedge clk);
        issue(4'd7, 4'd1, 1'b0);
        wait_done(0, lat, bcnt, seen);
        issue(4'd2, 4'd2, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_immediate", 32'(busy), 1);
        chk("b2b_S_held", 32'(S), 8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_S_stable", 32'({S, cout, v}), 32'({4'd8, 1'b0, 1'b1}));
        end
        @(negedge clk);
        chk("b2b_done", 32'(done), 1);
        chk("b2b_result", 32'({S, cout, v}), 32'({4'd4, 1'b0, 1'b0}));

        // Reset in the second RUN cycle abandons the operation.
        @(negedge clk);
        issue(4'd5, 4'd3, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 32'({busy, done, cout, v, S}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_mid_no_done", ndone, 0);
        @(negedge clk);
        issue(4'd7, 4'd1, 1'b0);
        wait_done(0, lat, bcnt, seen);
        chk("rst_fresh_result", 32'({S, cout, v}), 32'({4'd8, 1'b0, 1'b1}));
        chk("rst_fresh_lat", lat, W + 1);

        // Exhaustive sweep against the golden model.
        for (int mm = 0; mm < 2; mm++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    @(negedge clk);
                    issue(4'(a), 4'(b), 1'(mm));
                    wait_done(0, lat, bcnt, seen);
                    g = golden(4'(a), 4'(b), 1'(mm));
                    chk($sformatf("sweep a=%0d b=%0d m=%0d {S,cout,v}", a, b, mm),
                        32'({S, cout, v}), 32'(g));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
